// File: rtl/afifo_wr_frontend.sv
// afifo_wr_frontend: write-side front end of the asynchronous FIFO.
// Buffers producer words in a 2-entry skid buffer (head/tail) and drives
// winc/wdata into the write-pointer stage, honouring its registered wfull.
// in_ready depends only on local state, so wfull never reaches it
// combinationally.
// Optional feature macro: AFIFO_WR_STALL_CNT_EN (saturating wfull stall counter).
//
// Handshake: a word moves across in_valid/in_ready on a rising wclk edge where
// both are high. in_valid may be raised at any time and must then hold
// in_data stable until accepted; in_ready never depends on in_valid or wfull.
module afifo_wr_frontend #(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 wfull,
    output logic                 winc,
    output logic [DATA_SIZE-1:0] wdata,
    output logic [CNT_W-1:0]     wr_count,
    output logic [CNT_W-1:0]     stall_count,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] head;
    logic [DATA_SIZE-1:0] tail;
    logic [CNT_W-1:0]     wr_count_q;
    logic                 push;
    logic                 pop;

    // Ready and write enable are both forced low while reset is asserted.
    assign in_ready  = ~wrst & (state != S_TWO);
    assign winc      = ~wrst & (state != S_EMPTY) & ~wfull;
    assign wdata     = head;
    assign push      = in_valid & in_ready;
    assign pop       = winc;
    assign wr_count  = wr_count_q;
    assign state_dbg = state;

    // Skid-buffer FSM: head always holds the oldest word, tail the second.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state <= S_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) begin
                        state <= S_ONE;
                        head  <= in_data;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        state <= S_TWO;
                        tail  <= in_data;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        state <= S_ONE;
                        head  <= tail;
                    end
                end
                default: begin
                    state <= S_EMPTY;
                end
            endcase
        end
    end

    // Count words handed to the FIFO; wraps naturally at all-ones.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wr_count_q <= '0;
        end else if (winc) begin
            wr_count_q <= wr_count_q + 1'b1;
        end
    end

`ifdef AFIFO_WR_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Count cycles with buffered data blocked by wfull, saturating at all-ones.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_q <= '0;
        end else if ((state != S_EMPTY) && wfull && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_afifo_wr_frontend.sv
// Directed bench for afifo_wr_frontend: reset, streaming, backpressure,
// push/pop in S_ONE, mid-operation reset and stall counting.
module tb_afifo_wr_frontend;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          wfull;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] stall_count;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_stall;

    // Clock / reset
    always #5 wclk = ~wclk;

    afifo_wr_frontend #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .wr_count   (wr_count),
        .stall_count(stall_count),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Driver helpers: inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic sample();
        @(negedge wclk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        wfull    = f;
    endtask

    // Scoreboard: every winc must carry the next expected word.
    always @(negedge wclk) begin
        if (winc) begin
            if (exp_q.size() == 0) begin
                check("winc_unexpected", 32'd1, 32'd0);
            end else begin
                check("wdata_order", 32'(wdata), 32'(exp_q.pop_front()));
            end
            check("winc_while_full", 32'(wfull), 32'd0);
        end
    end

    initial begin
        wrst = 1'b1;
        drive(1'b1, 8'h77, 1'b0);

        // Reset held 3 cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_winc", 32'(winc), 32'd0);
            step();
        end
        sample();
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_stall", 32'(stall_count), 32'd0);
        step();
        wrst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        sample();
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_winc", 32'(winc), 32'd0);
        step();

        // Streaming 0x01..0x10 with wfull low.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            exp_q.push_back(DW'(i));
            sample();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_winc", 32'(winc), (i > 1) ? 32'd1 : 32'd0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0);
        sample();
        check("stream_last_winc", 32'(winc), 32'd1);
        check("stream_last_wdata", 32'(wdata), 32'h10);
        step();
        sample();
        check("stream_idle_winc", 32'(winc), 32'd0);
        check("stream_wr_count", 32'(wr_count), 32'd16);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);
        step();

        // Backpressure: wfull high while offering A1, A2, A3.
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        drive(1'b1, 8'hA1, 1'b1);
        sample();
        check("bp_a1_ready", 32'(in_ready), 32'd1);
        check("bp_a1_winc", 32'(winc), 32'd0);
        step();
        drive(1'b1, 8'hA2, 1'b1);
        sample();
        check("bp_a2_ready", 32'(in_ready), 32'd1);
        check("bp_a2_winc", 32'(winc), 32'd0);
        step();
        drive(1'b1, 8'hA3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            sample();
            check("bp_full_ready", 32'(in_ready), 32'd0);
            check("bp_full_winc", 32'(winc), 32'd0);
            check("bp_full_state", 32'(state_dbg), 32'd2);
            step();
        end
        drive(1'b1, 8'hA3, 1'b0);
        sample();
        check("bp_drain1_winc", 32'(winc), 32'd1);
        check("bp_drain1_wdata", 32'(wdata), 32'hA1);
        check("bp_drain1_ready", 32'(in_ready), 32'd0);
        step();
        sample();
        check("bp_drain2_winc", 32'(winc), 32'd1);
        check("bp_drain2_wdata", 32'(wdata), 32'hA2);
        check("bp_drain2_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        sample();
        check("bp_drain3_winc", 32'(winc), 32'd1);
        check("bp_drain3_wdata", 32'(wdata), 32'hA3);
        step();
        sample();
        check("bp_idle_winc", 32'(winc), 32'd0);
        check("bp_wr_count", 32'(wr_count), 32'd19);
        step();

        // Simultaneous push/pop in S_ONE.
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h66);
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b1, 8'h66, 1'b0);
        sample();
        check("pp_winc", 32'(winc), 32'd1);
        check("pp_wdata", 32'(wdata), 32'h55);
        check("pp_ready", 32'(in_ready), 32'd1);
        step();
        drive(1'b0, 8'h00, 1'b0);
        sample();
        check("pp_state_one", 32'(state_dbg), 32'd1);
        check("pp_next_wdata", 32'(wdata), 32'h66);
        check("pp_next_winc", 32'(winc), 32'd1);
        step();
        sample();
        check("pp_empty_state", 32'(state_dbg), 32'd0);
        check("pp_wr_count", 32'(wr_count), 32'd21);
        step();

        // Reset mid-operation with S_TWO holding 0x11, 0x22 (never written).
        drive(1'b1, 8'h11, 1'b1);
        step();
        drive(1'b1, 8'h22, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1);
        sample();
        check("mid_state_two", 32'(state_dbg), 32'd2);
        step();
        wrst = 1'b1;
        sample();
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_winc", 32'(winc), 32'd0);
        step();
        wrst = 1'b0;
        sample();
        check("mid_state_empty", 32'(state_dbg), 32'd0);
        check("mid_wr_count", 32'(wr_count), 32'd0);
        check("mid_stall", 32'(stall_count), 32'd0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("mid_no_winc", 32'(winc), 32'd0);
            step();
        end

        // Stall counting: one word buffered with wfull high for 5 cycles.
        exp_q.push_back(8'h5A);
        drive(1'b1, 8'h5A, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sample();
            check("stall_hold_winc", 32'(winc), 32'd0);
            step();
        end
`ifdef AFIFO_WR_STALL_CNT_EN
        exp_stall = 16'd5;
`else
        exp_stall = 16'd0;
`endif
        drive(1'b0, 8'h00, 1'b0);
        sample();
        check("stall_count", 32'(stall_count), 32'(exp_stall));
        check("stall_release_winc", 32'(winc), 32'd1);
        step();
        sample();
        check("stall_count_hold", 32'(stall_count), 32'(exp_stall));
        check("final_wr_count", 32'(wr_count), 32'd1);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
